// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one registered ALU (one-cycle result latency) between NREQ
// requesters. Requests are arbitrated round-robin. The winner's op-code and
// operands are registered onto the ALU inputs, and the ALU result is captured
// and held until the owning requester accepts it. Only one operation is in
// flight at a time.
//
// Optional feature macro: ALU_ARB_FASTPATH_EN
//   When defined, the cycle that completes a response handshake also
//   arbitrates and can accept a new request. Back-to-back ops then take
//   3 cycles instead of 4.
//
// Ports:
//   clk          in   rising-edge system clock
//   resetn       in   asynchronous active-low reset
//   req_valid    in   [NREQ]         request valid per requester
//   req_ready    out  [NREQ]         request accepted (one-hot or zero)
//   req_ctrl     in   [NREQ*CTRL_W]  packed op-codes, requester i at [i*CTRL_W +: CTRL_W]
//   req_a        in   [NREQ*DATA_W]  packed operand A, same packing
//   req_b        in   [NREQ*DATA_W]  packed operand B, same packing
//   rsp_valid    out  [NREQ]         result valid per requester (one-hot or zero)
//   rsp_ready    in   [NREQ]         requester accepts result
//   rsp_data     out  [DATA_W]       shared result bus, qualified by rsp_valid
//   alu_ctrl     out  [CTRL_W]       registered ALU op-code
//   alu_a        out  [DATA_W]       registered ALU operand A
//   alu_b        out  [DATA_W]       registered ALU operand B
//   alu_y        in   [DATA_W]       ALU result (valid in CAPT)
//   dbg_state_o  out  [2]            current FSM state (IDLE=0 EXEC=1 CAPT=2 RESP=3)
//
// Handshake semantics (both channels): a transfer happens on a rising edge
// where valid and ready are both high. The sender holds valid and its payload
// stable until that edge. req_ready is combinational from req_valid and is
// only raised for a requester whose req_valid is high. rsp_valid/rsp_data
// are registered and held until the owner's rsp_ready completes the transfer.
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int NREQ   = 2,
    parameter int DATA_W = 16,
    parameter int CTRL_W = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*CTRL_W-1:0]   req_ctrl,
    input  logic [NREQ*DATA_W-1:0]   req_a,
    input  logic [NREQ*DATA_W-1:0]   req_b,
    output logic [NREQ-1:0]          rsp_valid,
    input  logic [NREQ-1:0]          rsp_ready,
    output logic [DATA_W-1:0]        rsp_data,
    output logic [CTRL_W-1:0]        alu_ctrl,
    output logic [DATA_W-1:0]        alu_a,
    output logic [DATA_W-1:0]        alu_b,
    input  logic [DATA_W-1:0]        alu_y,
    output logic [1:0]               dbg_state_o
);

    localparam int OWN_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [OWN_W-1:0]    owner_q, owner_d;
    logic [OWN_W-1:0]    last_q, last_d;
    logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [CTRL_W-1:0]   alu_ctrl_q, alu_ctrl_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;

    logic                any_req;
    logic                found;
    logic [OWN_W-1:0]    grant_idx;
    logic                take;

    // Round-robin pick: first valid requester strictly after last_q, wrapping.
    // Searching k = 1..NREQ means last_q itself is considered last.
    always_comb begin
        any_req   = |req_valid;
        found     = 1'b0;
        grant_idx = last_q;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && req_valid[(int'(last_q) + k) % NREQ]) begin
                found     = 1'b1;
                grant_idx = OWN_W'((int'(last_q) + k) % NREQ);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        alu_ctrl_d  = alu_ctrl_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        req_ready   = '0;
        take        = 1'b0;

        case (state_q)
            IDLE: begin
                take = any_req;
            end
            EXEC: begin
                // ALU registers alu_* at the end of this cycle.
                state_d = CAPT;
            end
            CAPT: begin
                rsp_data_d           = alu_y;
                rsp_valid_d[owner_q] = 1'b1;
                state_d              = RESP;
            end
            RESP: begin
                // Only the owner's rsp_ready completes the response.
                if (rsp_ready[owner_q]) begin
                    rsp_valid_d = '0;
                    state_d     = IDLE;
`ifdef ALU_ARB_FASTPATH_EN
                    take = any_req;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (take) begin
            req_ready[grant_idx] = 1'b1;
            alu_ctrl_d = req_ctrl[int'(grant_idx)*CTRL_W +: CTRL_W];
            alu_a_d    = req_a[int'(grant_idx)*DATA_W +: DATA_W];
            alu_b_d    = req_b[int'(grant_idx)*DATA_W +: DATA_W];
            owner_d    = grant_idx;
            last_d     = grant_idx;
            state_d    = EXEC;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            last_q      <= OWN_W'(NREQ - 1);
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            alu_ctrl_q  <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            alu_ctrl_q  <= alu_ctrl_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign alu_ctrl    = alu_ctrl_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign dbg_state_o = state_q;

endmodule
